// File: rtl/regfile_scanner.sv
// Read-side sequencer: walks the register file's registered read port over a masked
// subset of registers and streams each value out on a valid/ready beat.
module regfile_scanner #(
  parameter int NUM_REGS = 8,
  parameter int SEL_W    = 3,
  parameter int DATA_W   = 16
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [NUM_REGS-1:0] reg_mask_i,
  output logic [SEL_W-1:0]    rd_sel_o,
  input  logic [DATA_W-1:0]   rd_data_i,
  output logic [DATA_W-1:0]   out_data_o,
  output logic [SEL_W-1:0]    out_idx_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic                busy_o,
  output logic                done_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_PRESENT,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [NUM_REGS-1:0] mask_q, mask_d;
  logic [SEL_W-1:0]    idx_q, idx_d;
  logic [SEL_W-1:0]    rd_sel_q, rd_sel_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [SEL_W-1:0]    out_idx_q, out_idx_d;
  logic [NUM_REGS-1:0] mask_rem;

  function automatic logic [SEL_W-1:0] lowest_set(input logic [NUM_REGS-1:0] m);
    logic [SEL_W-1:0] r;
    r = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (m[i]) r = SEL_W'(i);
    end
    return r;
  endfunction

  // Lower bits are already cleared, so the next set bit is the lowest remaining one.
  always_comb begin
    mask_rem = mask_q & ~(NUM_REGS'(1) << idx_q);
  end

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    idx_d      = idx_q;
    rd_sel_d   = rd_sel_q;
    out_data_d = out_data_q;
    out_idx_d  = out_idx_q;
    if (abort_i && state_q != S_IDLE) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i && !abort_i) begin
            mask_d = reg_mask_i;
            if (|reg_mask_i) begin
              idx_d    = lowest_set(reg_mask_i);
              rd_sel_d = lowest_set(reg_mask_i);
              state_d  = S_ISSUE;
            end else begin
              state_d = S_DONE;
            end
          end
        end
        S_ISSUE: state_d = S_WAIT;
        S_WAIT: begin
          out_data_d = rd_data_i;
          out_idx_d  = idx_q;
          state_d    = S_PRESENT;
        end
        S_PRESENT: begin
          if (out_ready_i) begin
            mask_d = mask_rem;
            if (|mask_rem) begin
              idx_d    = lowest_set(mask_rem);
              rd_sel_d = lowest_set(mask_rem);
              state_d  = S_ISSUE;
            end else begin
              state_d = S_DONE;
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      mask_q     <= '0;
      idx_q      <= '0;
      rd_sel_q   <= '0;
      out_data_q <= '0;
      out_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      idx_q      <= idx_d;
      rd_sel_q   <= rd_sel_d;
      out_data_q <= out_data_d;
      out_idx_q  <= out_idx_d;
    end
  end

  assign rd_sel_o    = rd_sel_q;
  assign out_data_o  = out_data_q;
  assign out_idx_o   = out_idx_q;
  assign out_valid_o = (state_q == S_PRESENT);
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_DONE);

endmodule

// File: tb/tb_regfile_scanner.sv
// Bench for regfile_scanner: behavioural register file, beat monitor and an
// expected-beat list built straight from the mask and the register contents.
module tb_regfile_scanner;

  logic        clk = 1'b0;
  logic        reset, start, abort, out_ready;
  logic [7:0]  reg_mask;
  logic [2:0]  rd_sel, out_idx;
  logic [15:0] rd_data, out_data;
  logic        out_valid, busy, done;

  logic        we;
  logic [2:0]  waddr;
  logic [15:0] wdata;
  logic [15:0] regs [8];
  logic [15:0] mdl [8];

  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  int          bad_sel = 0;
  logic [7:0]  cur_mask = 8'h00;
  logic [18:0] got_q[$];
  logic [18:0] exp_q[$];

  always #5 clk = ~clk;

  regfile_scanner dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .abort_i(abort),
    .reg_mask_i(reg_mask), .rd_sel_o(rd_sel), .rd_data_i(rd_data),
    .out_data_o(out_data), .out_idx_o(out_idx), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .busy_o(busy), .done_o(done)
  );

  // Register file with a registered, pre-write read port
  always @(posedge clk) begin
    rd_data <= regs[rd_sel];
    if (we) regs[waddr] <= wdata;
  end

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready && !abort) got_q.push_back({out_idx, out_data});
    if (done) done_cnt++;
    if (busy && !cur_mask[rd_sel]) bad_sel++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [15:0] d);
    we = 1'b1; waddr = a; wdata = d; mdl[a] = d;
    tick;
    we = 1'b0;
  endtask

  task automatic build_exp(input logic [7:0] m);
    exp_q.delete();
    for (int i = 0; i < 8; i++)
      if (m[i]) exp_q.push_back({3'(i), mdl[i]});
  endtask

  task automatic start_scan(input logic [7:0] m);
    cur_mask = m; reg_mask = m; start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, input bit rnd, input int d0);
    int c = 0;
    while (done_cnt == d0 && c < max_cyc) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      #1;
      c++;
      if (done_cnt == d0) tick;
    end
    checks++;
    if (done_cnt == d0) begin
      errors++; $display("FAIL done_timeout: no Done within %0d cycles", max_cyc);
    end
    out_ready = 1'b1;
    tick;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0; reg_mask = 8'h00; we = 1'b0;
    waddr = 3'd0; wdata = 16'h0;
    repeat (2) tick;
    @(negedge clk);
    checks++;
    if ({rd_sel, out_data, out_idx, out_valid, busy, done} !== 25'd0) begin
      errors++; $display("FAIL reset_outputs: got %h required 0", {rd_sel, out_data, out_idx, out_valid, busy, done});
    end
    tick;
    reset = 1'b0;
    tick;
  endtask

  task automatic test_full_dump;
    int d0;
    for (int n = 0; n < 8; n++) write_reg(3'(n), 16'(16'h1111 * n));
    out_ready = 1'b1; got_q.delete(); build_exp(8'hFF); d0 = done_cnt;
    start_scan(8'hFF);
    @(negedge clk);
    checks++;
    if ({out_valid, busy} !== 2'b01) begin
      errors++; $display("FAIL full_cycle1: valid,busy got %b required 01", {out_valid, busy});
    end
    tick; @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL full_cycle2: valid got %b required 0", out_valid); end
    tick; @(negedge clk);
    checks++;
    if ({out_valid, out_idx, out_data} !== {1'b1, 3'd0, 16'h0000}) begin
      errors++; $display("FAIL full_first_beat: got %h required %h", {out_valid, out_idx, out_data}, {1'b1, 3'd0, 16'h0000});
    end
    tick;
    wait_done(100, 1'b0, d0);
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL full_count: got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL full_beat%0d: got %h required %h", i, got_q[i], exp_q[i]); end
    end
    @(negedge clk);
    checks++;
    if ({busy, done_cnt == d0 + 1} !== 2'b01) begin
      errors++; $display("FAIL full_done: busy got %b, done pulses got %0d required 1", busy, done_cnt - d0);
    end
    tick;
  endtask

  task automatic test_sparse;
    int d0;
    write_reg(3'd2, 16'hBEEF); write_reg(3'd5, 16'hCAFE); write_reg(3'd7, 16'hF00D);
    got_q.delete(); build_exp(8'b1010_0100); d0 = done_cnt; bad_sel = 0;
    start_scan(8'b1010_0100);
    wait_done(100, 1'b0, d0);
    checks++;
    if (got_q.size() != 3) begin errors++; $display("FAIL sparse_count: got %0d required 3", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL sparse_beat%0d: got %h required %h", i, got_q[i], exp_q[i]); end
    end
    checks++;
    if (bad_sel != 0) begin errors++; $display("FAIL sparse_rd_sel: unmasked selects got %0d required 0", bad_sel); end
  endtask

  task automatic test_empty;
    int d0;
    got_q.delete(); d0 = done_cnt;
    start_scan(8'h00);
    @(negedge clk);
    checks++;
    if ({done, out_valid, busy} !== 3'b101) begin
      errors++; $display("FAIL empty_done: done,valid,busy got %b required 101", {done, out_valid, busy});
    end
    tick; @(negedge clk);
    checks++;
    if ({done, busy} !== 2'b00) begin errors++; $display("FAIL empty_idle: done,busy got %b required 00", {done, busy}); end
    tick;
    checks++;
    if (got_q.size() != 0 || done_cnt != d0 + 1) begin
      errors++; $display("FAIL empty_beats: beats got %0d, done pulses %0d required 0,1", got_q.size(), done_cnt - d0);
    end
  endtask

  task automatic test_backpressure;
    int d0;
    int c = 0;
    out_ready = 1'b1; got_q.delete(); build_exp(8'hFF); d0 = done_cnt;
    start_scan(8'hFF);
    while (!(out_valid && out_idx == 3'd3) && c < 100) begin tick; c++; end
    out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, out_idx, out_data} !== {1'b1, 3'd3, mdl[3]}) begin
        errors++; $display("FAIL bp_hold%0d: got %h required %h", k, {out_valid, out_idx, out_data}, {1'b1, 3'd3, mdl[3]});
      end
      tick;
    end
    wait_done(100, 1'b0, d0);
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL bp_count: got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_beat%0d: got %h required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random;
    int d0;
    logic [7:0] m;
    for (int t = 0; t < 6; t++) begin
      for (int n = 0; n < 8; n++) write_reg(3'(n), 16'($urandom));
      m = (t == 0) ? 8'h80 : 8'($urandom);
      got_q.delete(); build_exp(m); d0 = done_cnt;
      start_scan(m);
      wait_done(300, 1'b1, d0);
      checks++;
      if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand%0d_count: got %0d required %0d", t, got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand%0d_beat%0d: got %h required %h", t, i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_collision;
    int d0;
    write_reg(3'd4, 16'h0AAA);
    got_q.delete(); build_exp(8'h10); d0 = done_cnt;
    start_scan(8'h10);
    we = 1'b1; waddr = 3'd4; wdata = 16'h1234; mdl[4] = 16'h1234;
    tick;
    we = 1'b0;
    wait_done(100, 1'b0, d0);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== {3'd4, 16'h0AAA}) begin
      errors++; $display("FAIL collision_snapshot: beats %0d first %h required 1 beat %h", got_q.size(), got_q.size() ? got_q[0] : 19'h0, {3'd4, 16'h0AAA});
    end
    got_q.delete(); build_exp(8'h10); d0 = done_cnt;
    start_scan(8'h10);
    wait_done(100, 1'b0, d0);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      errors++; $display("FAIL collision_rescan: beats %0d first %h required 1 beat %h", got_q.size(), got_q.size() ? got_q[0] : 19'h0, exp_q[0]);
    end
  endtask

  task automatic test_abort_reset;
    int d0;
    int c = 0;
    out_ready = 1'b1; got_q.delete(); d0 = done_cnt;
    start_scan(8'hFF);
    while (!out_valid && c < 20) begin tick; c++; end
    abort = 1'b1;
    tick;
    abort = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, out_valid} !== 2'b00) begin errors++; $display("FAIL abort_idle: busy,valid got %b required 00", {busy, out_valid}); end
    repeat (3) tick;
    checks++;
    if (got_q.size() != 0 || done_cnt != d0) begin
      errors++; $display("FAIL abort_no_beat: beats %0d done pulses %0d required 0,0", got_q.size(), done_cnt - d0);
    end
    abort = 1'b1; start = 1'b1; reg_mask = 8'hFF;
    tick;
    abort = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_start_idle: busy got %b required 0", busy); end
    tick;
    start_scan(8'hFF);
    tick;
    reset = 1'b1;
    tick;
    @(negedge clk);
    checks++;
    if ({rd_sel, out_data, out_idx, out_valid, busy, done} !== 25'd0) begin
      errors++; $display("FAIL reset_mid_wait: got %h required 0", {rd_sel, out_data, out_idx, out_valid, busy, done});
    end
    tick;
    reset = 1'b0;
    tick;
    got_q.delete(); build_exp(8'h81); d0 = done_cnt;
    start_scan(8'h81);
    wait_done(100, 1'b0, d0);
    checks++;
    if (got_q.size() != 2) begin errors++; $display("FAIL post_reset_count: got %0d required 2", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL post_reset_beat%0d: got %h required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_full_dump;
    test_sparse;
    test_empty;
    test_backpressure;
    test_random;
    test_collision;
    test_abort_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
